// File: rtl/wb_arbiter_if.sv
// Write-back bus: ALU/MEM result, long-latency offer/ready, register-file write port, status.
// pending_mask is present only when WB_PENDING_MASK_EN is defined.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_reg;
  logic [31:0]     alu_data;
  logic            lw_valid;
  logic            lw_ready;
  logic [4:0]      lw_reg;
  logic [31:0]     lw_data;
  logic            stall_req;
  logic            regWrite;
  logic [4:0]      writeReg;
  logic [31:0]     writeData;
  logic [CNTW-1:0] fifo_count;
`ifdef WB_PENDING_MASK_EN
  logic [31:0]     pending_mask;

  modport master (
    output alu_valid, alu_reg, alu_data, lw_valid, lw_reg, lw_data,
    input  lw_ready, stall_req, regWrite, writeReg, writeData, fifo_count, pending_mask
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, lw_valid, lw_reg, lw_data,
    output lw_ready, stall_req, regWrite, writeReg, writeData, fifo_count, pending_mask
  );
`else
  modport master (
    output alu_valid, alu_reg, alu_data, lw_valid, lw_reg, lw_data,
    input  lw_ready, stall_req, regWrite, writeReg, writeData, fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, lw_valid, lw_reg, lw_data,
    output lw_ready, stall_req, regWrite, writeReg, writeData, fifo_count
  );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU path 1 cycle, long-latency path >=2 cycles via a DEPTH-entry FIFO; lw_ready drops when full,
// stall_req asks the ALU pipe to yield after STARVE_MAX non-drain cycles. Optional pending_mask under WB_PENDING_MASK_EN.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int CW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
  localparam logic [CW-1:0]   SMAX = CW'(STARVE_MAX);

  logic [4:0]      ent_reg  [DEPTH];
  logic [31:0]     ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   starve;

  logic            push;
  logic            pop;
  logic            alu_wr;
  logic            push_live;
  logic [CW-1:0]   starve_nxt;

  assign bus.lw_ready   = (count != FULL);
  assign bus.fifo_count = count;

  always_comb begin
    alu_wr    = bus.alu_valid && (bus.alu_reg != 5'd0);
    push      = bus.lw_valid && (count != FULL);
    pop       = !bus.alu_valid && (count != '0);
    // A same-cycle ALU write to the same register is architecturally newer.
    push_live = !(alu_wr && (bus.lw_reg == bus.alu_reg));
    if ((count == '0) || pop) begin
      starve_nxt = '0;
    end else if (starve >= SMAX) begin
      starve_nxt = starve;
    end else begin
      starve_nxt = starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
      ent_live      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      starve        <= '0;
      bus.stall_req <= 1'b0;
      bus.regWrite  <= 1'b0;
      bus.writeReg  <= '0;
      bus.writeData <= '0;
    end else begin
      if (alu_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_reg[i] == bus.alu_reg) ent_live[i] <= 1'b0;
        end
      end
      if (push) begin
        ent_reg[wr_ptr]  <= bus.lw_reg;
        ent_data[wr_ptr] <= bus.lw_data;
        ent_live[wr_ptr] <= push_live;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        ent_live[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      count         <= count + CNTW'(push) - CNTW'(pop);
      starve        <= starve_nxt;
      bus.stall_req <= (starve_nxt >= SMAX);

      if (bus.alu_valid) begin
        bus.regWrite  <= alu_wr;
        bus.writeReg  <= bus.alu_reg;
        bus.writeData <= bus.alu_data;
      end else if (pop) begin
        // Killed or reg-0 entries still consume the slot but do not write.
        bus.regWrite  <= ent_live[rd_ptr] && (ent_reg[rd_ptr] != 5'd0);
        bus.writeReg  <= ent_reg[rd_ptr];
        bus.writeData <= ent_data[rd_ptr];
      end else begin
        bus.regWrite  <= 1'b0;
      end
    end
  end

`ifdef WB_PENDING_MASK_EN
  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live[i]) bus.pending_mask[ent_reg[i]] = 1'b1;
    end
    bus.pending_mask[0] = 1'b0;
  end
`endif
endmodule
